// File: rtl/seg_scan_pkg.sv
// Shared constants and the 7-segment font for the digit scan driver.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 6;

  // Idle pin levels for active-low boards; active-high builds invert these.
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE_LO = 6'h3F;
  localparam logic [7:0]            SEG_IDLE_LO = 8'hFF;

  // Active-high g..a, bit 0 = segment a.
  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Value-in / pins-out bundle of the seven-segment scan driver.
interface seg_scan_driver_if;
  logic [23:0] num;
  logic [5:0]  dp;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (output num, dp, input sel, seg);
  modport slave  (input num, dp, output sel, seg);
endinterface

// File: rtl/seg_font_dec.sv
// Combinational nibble to active-high 7-segment glyph.
module seg_font_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);
  assign glyph = seg_font(nib);
endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with frame-coherent shadow regs.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter bit SEG_ACT_LO = 1'b1,
  parameter bit SEL_ACT_LO = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seg_scan_driver_if.slave bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACT_LO ? SEL_IDLE_LO : ~SEL_IDLE_LO;
  localparam logic [7:0]            SEG_IDLE = SEG_ACT_LO ? SEG_IDLE_LO : ~SEG_IDLE_LO;

  logic [CNT_W-1:0]                cnt;
  logic [2:0]                      idx;
  logic [NUM_DIGITS-1:0][3:0]      shadow;
  logic [NUM_DIGITS-1:0]           dp_sh;
  logic [NUM_DIGITS-1:0]           sel_q;
  logic [7:0]                      seg_q;
  logic                            wrap;
  logic [3:0]                      nib;
  logic                            dp_cur;
  logic                            show;
  logic                            active;
  logic [6:0]                      glyph;
  logic [NUM_DIGITS-1:0]           sel_raw;
  logic [7:0]                      seg_raw;

  assign wrap = (cnt == CNT_LAST);

  // Snapshot is taken only at the very end of a frame so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      dp_sh  <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
      if (wrap && idx == 3'd5) begin
        shadow <= bus.num;
        dp_sh  <= bus.dp;
      end
    end
  end

  always_comb begin
    nib    = '0;
    dp_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx == 3'(i)) begin
        nib    = shadow[i];
        dp_cur = dp_sh[i];
      end
  end

`ifdef SEG_LZ_BLANK_EN
  // A digit is lit if it or any higher digit is non-zero; digit 0 always lit.
  always_comb begin
    show = (idx == 3'd0);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(idx) && shadow[i] != 4'h0) show = 1'b1;
  end
`else
  assign show = 1'b1;
`endif

  seg_font_dec u_font (.nib(nib), .glyph(glyph));

  assign active  = (cnt >= BLANK_V) && (idx < 3'd6);
  assign sel_raw = 6'b1 << idx;
  assign seg_raw = {dp_cur, show ? glyph : 7'h00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= SEL_IDLE;
      seg_q <= SEG_IDLE;
    end else if (active) begin
      sel_q <= SEL_ACT_LO ? ~sel_raw : sel_raw;
      seg_q <= SEG_ACT_LO ? ~seg_raw : seg_raw;
    end else begin
      sel_q <= SEL_IDLE;
      seg_q <= SEG_IDLE;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;

endmodule
